// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code state encodings and conversion helper
package gray_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   localparam int GRAY_MAX_W = 32;

   // Width-generic: narrower codes are zero-extended, and zero high bits
   // leave the XOR-prefix result of the low bits unchanged.
   function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = g;
      for (int s = 1; s < GRAY_MAX_W; s = s * 2) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational XOR-prefix Gray to binary converter
module gray2bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Each binary bit is the XOR of its Gray bit and every Gray bit above it;
   // written as a reduction so there is no self-referencing chain.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin[i] = ^(gray >> i);
   end

endmodule

// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - registered Gray decoder with forward-count legality monitor
module gray_decoder
   import gray_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clear,
   input  logic             In_valid,
   input  logic [WIDTH-1:0] Gray_in,
   output logic [WIDTH-1:0] Bin_out,
   output logic             Out_valid,
   output logic             Wrap,
   output logic             Step_err,
   output logic             Err_sticky,
   output logic [CNT_W-1:0] Wrap_count,
   output logic [1:0]       State
);

   localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] BIN_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             out_valid_d, wrap_d, step_err_d, sticky_d;
   logic [CNT_W-1:0] count_d;
   logic [WIDTH-1:0] bin_new;
   logic [WIDTH-1:0] diff;

   gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
      .gray (Gray_in),
      .bin  (bin_new)
   );

   // bin_q doubles as the previous accepted value: both always update together.
   assign diff = bin_new - bin_q;

   // Next-state, output and counter decisions for the current sample.
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      out_valid_d = 1'b0;
      wrap_d      = 1'b0;
      step_err_d  = 1'b0;
      sticky_d    = Err_sticky;
      count_d     = Wrap_count;
      if (Clear) begin
         state_d  = ST_IDLE;
         sticky_d = 1'b0;
         count_d  = '0;
      end else if (In_valid) begin
         bin_d       = bin_new;
         out_valid_d = 1'b1;
         case (state_q)
            ST_IDLE: begin
               state_d = ST_TRACK;
            end
            ST_TRACK: begin
               if (diff == BIN_ZERO) begin
                  state_d = ST_TRACK;
               end else if (diff == BIN_ONE) begin
                  if (bin_q == BIN_MAX) begin
                     wrap_d = 1'b1;
                     if (Wrap_count != CNT_MAX) begin
                        count_d = Wrap_count + CNT_W'(1);
                     end
                  end
               end else begin
                  step_err_d = 1'b1;
                  sticky_d   = 1'b1;
                  state_d    = ST_ERROR;
               end
            end
            default: begin
               state_d = ST_ERROR;
            end
         endcase
      end
   end

   // State and output registers; reset is asynchronous and overrides the clock.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ST_IDLE;
         bin_q      <= '0;
         Out_valid  <= 1'b0;
         Wrap       <= 1'b0;
         Step_err   <= 1'b0;
         Err_sticky <= 1'b0;
         Wrap_count <= '0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         Out_valid  <= out_valid_d;
         Wrap       <= wrap_d;
         Step_err   <= step_err_d;
         Err_sticky <= sticky_d;
         Wrap_count <= count_d;
      end
   end

   assign Bin_out = bin_q;
   assign State   = state_q;

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - scoreboard bench for gray_decoder with directed vectors
module tb_gray_decoder;

   logic       Clk;
   logic       Reset;
   logic       Clear;
   logic       In_valid;
   logic [2:0] Gray_in;
   logic [2:0] Bin_out;
   logic       Out_valid;
   logic       Wrap;
   logic       Step_err;
   logic       Err_sticky;
   logic [7:0] Wrap_count;
   logic [1:0] State;

   typedef struct packed {
      logic [2:0] bin;
      logic       wrap;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [2:0] gtab [8];

   gray_decoder #(.WIDTH(3), .CNT_W(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Clear      (Clear),
      .In_valid   (In_valid),
      .Gray_in    (Gray_in),
      .Bin_out    (Bin_out),
      .Out_valid  (Out_valid),
      .Wrap       (Wrap),
      .Step_err   (Step_err),
      .Err_sticky (Err_sticky),
      .Wrap_count (Wrap_count),
      .State      (State)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic send(input logic [2:0] g, input logic [2:0] b, input logic w, input logic e);
      exp_t t;
      @(posedge Clk);
      #1;
      In_valid = 1'b1;
      Gray_in  = g;
      t.bin  = b;
      t.wrap = w;
      t.err  = e;
      exp_q.push_back(t);
   endtask

   task automatic idle();
      @(posedge Clk);
      #1;
      In_valid = 1'b0;
   endtask

   task automatic do_clear();
      @(posedge Clk);
      #1;
      Clear    = 1'b1;
      In_valid = 1'b0;
      @(posedge Clk);
      #1;
      Clear = 1'b0;
   endtask

   // Monitor: every Out_valid pulse consumes one expected entry.
   initial begin
      exp_t t;
      forever begin
         @(negedge Clk);
         if (Out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               t = exp_q.pop_front();
               check("bin_out", Bin_out, t.bin);
               check("wrap", Wrap, t.wrap);
               check("step_err", Step_err, t.err);
            end
         end else if (Wrap || Step_err) begin
            check("flag_without_valid", {Wrap, Step_err}, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      gtab[0] = 3'd0; gtab[1] = 3'd1; gtab[2] = 3'd3; gtab[3] = 3'd2;
      gtab[4] = 3'd6; gtab[5] = 3'd7; gtab[6] = 3'd5; gtab[7] = 3'd4;
      Reset    = 1'b0;
      Clear    = 1'b0;
      In_valid = 1'b0;
      Gray_in  = 3'd0;
      #12;
      check("rst_bin_out", Bin_out, 0);
      check("rst_out_valid", Out_valid, 0);
      check("rst_sticky", Err_sticky, 0);
      check("rst_wrap_count", Wrap_count, 0);
      check("rst_state", State, 0);
      @(negedge Clk);
      Reset = 1'b1;

      // 1: full forward count with a single wrap
      send(3'd0, 3'd0, 0, 0);
      send(3'd1, 3'd1, 0, 0);
      send(3'd3, 3'd2, 0, 0);
      send(3'd2, 3'd3, 0, 0);
      send(3'd6, 3'd4, 0, 0);
      send(3'd7, 3'd5, 0, 0);
      send(3'd5, 3'd6, 0, 0);
      send(3'd4, 3'd7, 0, 0);
      send(3'd0, 3'd0, 1, 0);
      idle();
      @(negedge Clk);
      @(negedge Clk);
      check("t1_wrap_count", Wrap_count, 1);
      check("t1_state", State, 1);
      check("t1_sticky", Err_sticky, 0);
      check("t1_queue_empty", exp_q.size(), 0);

      // 2: illegal jump 1 -> 3, then ERROR keeps decoding without new pulses
      do_clear();
      send(3'd1, 3'd1, 0, 0);
      send(3'd2, 3'd3, 0, 1);
      idle();
      @(negedge Clk);
      check("t2_sticky", Err_sticky, 1);
      check("t2_state", State, 2);
      check("t2_bin_out", Bin_out, 3);
      send(3'd6, 3'd4, 0, 0);
      idle();
      @(negedge Clk);
      check("t2_state_hold", State, 2);

      // 3: wrap, then backward step 2 -> 1, then Clear
      do_clear();
      check("t3_clear_state", State, 0);
      check("t3_clear_sticky", Err_sticky, 0);
      send(3'd4, 3'd7, 0, 0);
      send(3'd0, 3'd0, 1, 0);
      send(3'd1, 3'd1, 0, 0);
      send(3'd3, 3'd2, 0, 0);
      send(3'd1, 3'd1, 0, 1);
      idle();
      @(negedge Clk);
      check("t3_wrap_count_pre", Wrap_count, 1);
      check("t3_state_err", State, 2);
      do_clear();
      check("t3_state", State, 0);
      check("t3_sticky", Err_sticky, 0);
      check("t3_wrap_count", Wrap_count, 0);

      // 4: hold and idle gaps
      send(3'd3, 3'd2, 0, 0);
      send(3'd3, 3'd2, 0, 0);
      idle();
      idle();
      send(3'd2, 3'd3, 0, 0);
      idle();
      @(negedge Clk);
      check("t4_state", State, 1);
      check("t4_sticky", Err_sticky, 0);

      // 5: Clear beats a same-cycle sample; next sample is unchecked
      @(posedge Clk);
      #1;
      Clear    = 1'b1;
      In_valid = 1'b1;
      Gray_in  = 3'd7;
      @(posedge Clk);
      #1;
      Clear    = 1'b0;
      In_valid = 1'b0;
      @(negedge Clk);
      check("t5_state", State, 0);
      check("t5_bin_hold", Bin_out, 3);
      send(3'd5, 3'd6, 0, 0);
      idle();
      @(negedge Clk);
      check("t5_state_track", State, 1);
      check("t5_sticky", Err_sticky, 0);

      // 6a: asynchronous reset between clock edges
      do_clear();
      send(3'd4, 3'd7, 0, 0);
      send(3'd0, 3'd0, 1, 0);
      idle();
      @(negedge Clk);
      check("t6_wrap_count_pre", Wrap_count, 1);
      In_valid = 1'b1;
      Gray_in  = 3'd1;
      #2;
      Reset = 1'b0;
      #1;
      check("t6_bin_out", Bin_out, 0);
      check("t6_state", State, 0);
      check("t6_wrap_count", Wrap_count, 0);
      check("t6_out_valid", Out_valid, 0);
      @(negedge Clk);
      In_valid = 1'b0;
      Reset    = 1'b1;
      send(3'd6, 3'd4, 0, 0);
      idle();
      @(negedge Clk);
      check("t6_state_after", State, 1);

      // 6b: 260 wraps saturate the counter at 255
      do_clear();
      send(3'd0, 3'd0, 0, 0);
      for (int w = 0; w < 260; w++) begin
         for (int k = 1; k <= 8; k++) begin
            send(gtab[k % 8], 3'(k % 8), (k == 8), 0);
         end
      end
      idle();
      @(negedge Clk);
      @(negedge Clk);
      check("sat_wrap_count", Wrap_count, 255);
      check("sat_sticky", Err_sticky, 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
